// File: rtl/debug_slave_cmd_queue.sv
// rtl/debug_slave_cmd_queue.sv - sysclk-side debug slave command front end
// Synchronises virtual-JTAG update strobes, queues captured commands, emits one-hot pop strobes.
module debug_slave_cmd_queue #(
  parameter int DR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int ACT_BIT     = 35,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  localparam int NUM_IR     = 2**IR_WIDTH,
  localparam int LVL_W      = $clog2(FIFO_DEPTH+1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vs_e1dr,
  input  logic                vs_uir,
  input  logic [IR_WIDTH-1:0] ir_in,
  input  logic [DR_WIDTH-1:0] sr,
  input  logic                cmd_ready,
  input  logic                ovf_clr,
  output logic                cmd_valid,
  output logic [IR_WIDTH-1:0] cmd_ir,
  output logic [DR_WIDTH-1:0] cmd_jdo,
  output logic [NUM_IR-1:0]   take_action,
  output logic [NUM_IR-1:0]   take_no_action,
  output logic                ir_update,
  output logic                overflow,
  output logic [LVL_W-1:0]    fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 1 + IR_WIDTH + DR_WIDTH;

  logic [SYNC_STAGES-1:0] r_e1dr_sync, r_uir_sync, r_sync_vld;
  logic                   r_e1dr_dly, r_uir_dly, r_e1dr_armed, r_uir_armed;
  logic                   w_e1dr_s, w_uir_s, w_sync_vld, w_push, w_uir_edge;

  assign w_e1dr_s   = r_e1dr_sync[SYNC_STAGES-1];
  assign w_uir_s    = r_uir_sync[SYNC_STAGES-1];
  assign w_sync_vld = r_sync_vld[SYNC_STAGES-1];

  // Arming waits until the chain holds real samples, so a level already high at reset release never arms.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e1dr_sync  <= '0;
      r_uir_sync   <= '0;
      r_sync_vld   <= '0;
      r_e1dr_dly   <= 1'b0;
      r_uir_dly    <= 1'b0;
      r_e1dr_armed <= 1'b0;
      r_uir_armed  <= 1'b0;
    end else begin
      r_e1dr_sync  <= {r_e1dr_sync[SYNC_STAGES-2:0], vs_e1dr};
      r_uir_sync   <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
      r_sync_vld   <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
      r_e1dr_dly   <= w_e1dr_s;
      r_uir_dly    <= w_uir_s;
      r_e1dr_armed <= r_e1dr_armed | (w_sync_vld & ~w_e1dr_s);
      r_uir_armed  <= r_uir_armed  | (w_sync_vld & ~w_uir_s);
    end
  end

  assign w_push     = r_e1dr_armed & w_e1dr_s & ~r_e1dr_dly;
  assign w_uir_edge = r_uir_armed  & w_uir_s  & ~r_uir_dly;

  logic [ENT_W-1:0]    r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]    r_level;
  logic [ENT_W-1:0]    w_head;
  logic                w_head_act, w_full, w_pop, w_wr_en, w_drop;
  logic [IR_WIDTH-1:0] w_head_ir;
  logic [NUM_IR-1:0]   w_onehot;

  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_act = w_head[ENT_W-1];
  assign w_head_ir  = w_head[DR_WIDTH +: IR_WIDTH];
  assign w_onehot   = NUM_IR'(1) << w_head_ir;
  assign w_full     = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_pop      = cmd_valid & cmd_ready;
  assign w_wr_en    = w_push & (~w_full | w_pop);
  assign w_drop     = w_push & w_full & ~w_pop;

  assign cmd_valid  = (r_level != '0);
  assign cmd_ir     = cmd_valid ? w_head_ir : '0;
  assign cmd_jdo    = cmd_valid ? w_head[DR_WIDTH-1:0] : '0;
  assign fifo_level = r_level;

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= {sr[ACT_BIT], ir_in, sr};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      ir_update      <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      take_action    <= (w_pop &  w_head_act) ? w_onehot : '0;
      take_no_action <= (w_pop & ~w_head_act) ? w_onehot : '0;
      ir_update      <= w_uir_edge;
      if (w_drop)       overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_debug_slave_cmd_queue.sv
// tb/tb_debug_slave_cmd_queue.sv - directed self-checking bench for debug_slave_cmd_queue
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_debug_slave_cmd_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        vs_e1dr, vs_uir, cmd_ready, ovf_clr;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        cmd_valid, ir_update, overflow;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_jdo;
  logic [3:0]  take_action, take_no_action;
  logic [2:0]  fifo_level;

  int n_cmp = 0;
  int n_err = 0;

  debug_slave_cmd_queue dut (
    .clk(clk), .reset(reset), .vs_e1dr(vs_e1dr), .vs_uir(vs_uir),
    .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .ovf_clr(ovf_clr),
    .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .cmd_jdo(cmd_jdo),
    .take_action(take_action), .take_no_action(take_no_action),
    .ir_update(ir_update), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  logic [1:0]  v_ir  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [37:0] v_sr  [5] = '{38'h8_1111_0000, 38'h0_2222_0001, 38'h8_3333_0002,
                             38'h0_4444_0003, 38'h8_5555_0004};
  logic [3:0]  v_ta  [5] = '{4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0001};
  logic [3:0]  v_tna [5] = '{4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic capture(input logic [1:0] ir, input logic [37:0] data);
    ir_in   = ir;
    sr      = data;
    vs_e1dr = 1'b1;
    repeat (4) tick();
    vs_e1dr = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1; vs_e1dr = 1'b1; vs_uir = 1'b0; cmd_ready = 1'b0; ovf_clr = 1'b0;
    ir_in = '0; sr = '0;
    repeat (3) tick();
    chk("rst_valid", 64'(cmd_valid), 64'd0);
    chk("rst_ir", 64'(cmd_ir), 64'd0);
    chk("rst_jdo", 64'(cmd_jdo), 64'd0);
    chk("rst_ta", 64'(take_action), 64'd0);
    chk("rst_tna", 64'(take_no_action), 64'd0);
    chk("rst_iru", 64'(ir_update), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_lvl", 64'(fifo_level), 64'd0);

    // Level high across reset release must not push.
    reset = 1'b0;
    repeat (10) tick();
    chk("hi_at_rel_valid", 64'(cmd_valid), 64'd0);
    chk("hi_at_rel_lvl", 64'(fifo_level), 64'd0);

    vs_e1dr = 1'b0;
    repeat (4) tick();
    ir_in = 2'b01; sr = 38'h8_0000_1234; vs_e1dr = 1'b1;
    tick(); tick();
    chk("lat_edge2_valid", 64'(cmd_valid), 64'd0);
    tick();
    chk("lat_edge3_valid", 64'(cmd_valid), 64'd1);
    chk("lat_ir", 64'(cmd_ir), 64'd1);
    chk("lat_jdo", 64'(cmd_jdo), 64'h8_0000_1234);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("pop1_ta", 64'(take_action), 64'b0010);
    chk("pop1_tna", 64'(take_no_action), 64'd0);
    chk("pop1_lvl", 64'(fifo_level), 64'd0);
    tick();
    chk("pop1_ta_end", 64'(take_action), 64'd0);
    vs_e1dr = 1'b0;
    repeat (3) tick();

    capture(2'b11, 38'h0_0000_ABCD);
    chk("na_ir", 64'(cmd_ir), 64'd3);
    chk("na_jdo", 64'(cmd_jdo), 64'h0_0000_ABCD);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("na_tna", 64'(take_no_action), 64'b1000);
    chk("na_ta", 64'(take_action), 64'd0);
    tick();
    chk("na_tna_end", 64'(take_no_action), 64'd0);

    // Five captures into a four-deep queue: the fifth is dropped.
    for (int i = 0; i < 4; i++) capture(v_ir[i], v_sr[i]);
    chk("fill_lvl", 64'(fifo_level), 64'd4);
    chk("fill_ovf", 64'(overflow), 64'd0);
    capture(v_ir[4], v_sr[4]);
    chk("ovf_lvl", 64'(fifo_level), 64'd4);
    chk("ovf_set", 64'(overflow), 64'd1);
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_ir", i), 64'(cmd_ir), 64'(v_ir[i]));
      chk($sformatf("drain%0d_jdo", i), 64'(cmd_jdo), 64'(v_sr[i]));
      tick();
      chk($sformatf("drain%0d_ta", i), 64'(take_action), 64'(v_ta[i]));
      chk($sformatf("drain%0d_tna", i), 64'(take_no_action), 64'(v_tna[i]));
    end
    cmd_ready = 1'b0;
    chk("drain_empty", 64'(cmd_valid), 64'd0);
    chk("drain_lvl", 64'(fifo_level), 64'd0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 64'(overflow), 64'd0);

    // Full queue: push coincident with pop keeps level, no overflow.
    for (int i = 0; i < 4; i++) capture(v_ir[i], v_sr[i]);
    ir_in = v_ir[4]; sr = v_sr[4]; vs_e1dr = 1'b1;
    tick(); tick();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("pushpop_lvl", 64'(fifo_level), 64'd4);
    chk("pushpop_ovf", 64'(overflow), 64'd0);
    chk("pushpop_ta", 64'(take_action), 64'b0001);
    tick();
    vs_e1dr = 1'b0;
    repeat (3) tick();

    // Drop coincident with ovf_clr: set wins.
    ir_in = 2'b11; sr = 38'h8_9999_9999; vs_e1dr = 1'b1;
    tick(); tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_vs_set_ovf", 64'(overflow), 64'd1);
    chk("clr_vs_set_lvl", 64'(fifo_level), 64'd4);
    tick();
    vs_e1dr = 1'b0;
    repeat (3) tick();
    cmd_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("wrap%0d_jdo", i), 64'(cmd_jdo), 64'(v_sr[i]));
      tick();
    end
    cmd_ready = 1'b0;
    chk("wrap_lvl", 64'(fifo_level), 64'd0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;

    // Update-IR pulse.
    capture(2'b10, 38'h0_0000_0077);
    vs_uir = 1'b1;
    tick(); tick();
    chk("uir_edge2", 64'(ir_update), 64'd0);
    tick();
    chk("uir_edge3", 64'(ir_update), 64'd1);
    vs_uir = 1'b0;
    tick();
    chk("uir_edge4", 64'(ir_update), 64'd0);
    chk("uir_lvl", 64'(fifo_level), 64'd1);
    repeat (3) tick();

    // Reset one edge into a capture, with one entry already queued.
    ir_in = 2'b01; sr = 38'h8_0000_0001; vs_e1dr = 1'b1;
    tick();
    reset = 1'b1;
    #2;
    chk("midrst_valid", 64'(cmd_valid), 64'd0);
    chk("midrst_lvl", 64'(fifo_level), 64'd0);
    chk("midrst_jdo", 64'(cmd_jdo), 64'd0);
    chk("midrst_ovf", 64'(overflow), 64'd0);
    tick();
    reset = 1'b0;
    repeat (10) tick();
    chk("midrst_nopush_valid", 64'(cmd_valid), 64'd0);
    chk("midrst_nopush_lvl", 64'(fifo_level), 64'd0);
    vs_e1dr = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
